// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control-token symbols (common with the
// transmit encoder), the receive alignment FSM states and symbol helpers.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} align_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == CTRL_TOKEN_00) || (word == CTRL_TOKEN_01) ||
           (word == CTRL_TOKEN_10) || (word == CTRL_TOKEN_11);
  endfunction

  // Returns {c1, c0}; only meaningful when the word is a control token.
  function automatic logic [1:0] ctrl_token_bits(input logic [9:0] word);
    logic [1:0] c;
    case (word)
      CTRL_TOKEN_01: c = 2'b01;
      CTRL_TOKEN_10: c = 2'b10;
      CTRL_TOKEN_11: c = 2'b11;
      default:       c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_decode_data(input logic [9:0] word);
    logic [7:0] q;
    logic [7:0] x;
    q = word[9] ? ~word[7:0] : word[7:0];
    x = q ^ {q[6:0], 1'b0};
    return word[8] ? x : {~x[7:1], x[0]};
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-boundary search: slips the deserializer until a run of control tokens
// is seen, then holds lock until no qualifying run shows up for LOSS_LEN cycles.
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int SEARCH_LEN = 2048,
  parameter int CTRL_RUN   = 8,
  parameter int SLIP_WAIT  = 4,
  parameter int LOSS_LEN   = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] word,
  output logic       bitslip,
  output logic       locked,
  output logic       is_ctrl
);

  localparam int WIN_W  = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int LOSS_W = (LOSS_LEN > 1) ? $clog2(LOSS_LEN) : 1;

  align_state_t      state, state_nxt;
  logic [WIN_W-1:0]  win_cnt, win_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_nxt;
  logic              run_full;

  assign is_ctrl  = is_ctrl_token(word);
  assign run_full = (run_cnt == RUN_W'(CTRL_RUN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      win_cnt  <= '0;
      run_cnt  <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_nxt;
      run_cnt  <= run_nxt;
      wait_cnt <= wait_nxt;
      loss_cnt <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    wait_nxt  = wait_cnt;
    loss_nxt  = loss_cnt;
    bitslip   = 1'b0;
    locked    = 1'b0;
    if (!is_ctrl)      run_nxt = '0;
    else if (run_full) run_nxt = run_cnt;
    else               run_nxt = run_cnt + RUN_W'(1);

    case (state)
      SEARCH: begin
        // A completed run takes priority over window expiry.
        if (run_full) begin
          state_nxt = LOCKED;
          win_nxt   = '0;
          loss_nxt  = '0;
        end else if (win_cnt == WIN_W'(SEARCH_LEN - 1)) begin
          state_nxt = SLIP;
          win_nxt   = '0;
        end else begin
          win_nxt = win_cnt + WIN_W'(1);
        end
      end
      SLIP: begin
        bitslip   = 1'b1;
        state_nxt = WAIT;
        wait_nxt  = '0;
      end
      WAIT: begin
        // Words seen while the deserializer settles must not count toward a run.
        run_nxt = '0;
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_nxt = SEARCH;
          win_nxt   = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      LOCKED: begin
        locked = 1'b1;
        if (run_full) begin
          loss_nxt = '0;
        end else if (loss_cnt == LOSS_W'(LOSS_LEN - 1)) begin
          state_nxt = SEARCH;
          loss_nxt  = '0;
          win_nxt   = '0;
        end else begin
          loss_nxt = loss_cnt + LOSS_W'(1);
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// One TMDS receive lane: aligns 10-bit symbols and decodes de/data/c0/c1,
// valid 2 cycles after the symbol; no backpressure, one symbol per clock.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_LEN = 2048,
  parameter int CTRL_RUN   = 8,
  parameter int SLIP_WAIT  = 4,
  parameter int LOSS_LEN   = 65536
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [7:0] data_out,
  output logic       c0,
  output logic       c1
);

  logic [9:0] word_s1;
  logic       is_ctrl;
  logic       de_s2;
  logic [7:0] data_s2;
  logic [1:0] ctrl_bits;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) word_s1 <= '0;
    else            word_s1 <= tmds_word;
  end

  tmds_word_align #(
    .SEARCH_LEN (SEARCH_LEN),
    .CTRL_RUN   (CTRL_RUN),
    .SLIP_WAIT  (SLIP_WAIT),
    .LOSS_LEN   (LOSS_LEN)
  ) u_align (
    .clk     (vga_clk),
    .rst_n   (sys_rst_n),
    .word    (word_s1),
    .bitslip (bitslip),
    .locked  (locked),
    .is_ctrl (is_ctrl)
  );

  assign ctrl_bits = ctrl_token_bits(word_s1);

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      de_s2   <= 1'b0;
      data_s2 <= '0;
      c0      <= 1'b0;
      c1      <= 1'b0;
    end else if (locked && is_ctrl) begin
      de_s2   <= 1'b0;
      data_s2 <= '0;
      c0      <= ctrl_bits[0];
      c1      <= ctrl_bits[1];
    end else if (locked) begin
      de_s2   <= 1'b1;
      data_s2 <= tmds_decode_data(word_s1);
    end else begin
      de_s2   <= 1'b0;
      data_s2 <= '0;
    end
  end

  // Gate with the live lock state so de drops on the same cycle as locked.
  assign de       = de_s2 & locked;
  assign data_out = locked ? data_s2 : 8'h00;

endmodule

// File: tb/tb_tmds_decoder.sv
// Randomized scoreboard bench for tmds_decoder: lock, decode, lock loss,
// reset during a slip and recovery from a rotated stream.
module tb_tmds_decoder;

  localparam int SEARCH_LEN = 64;
  localparam int CTRL_RUN   = 8;
  localparam int SLIP_WAIT  = 4;
  localparam int LOSS_LEN   = 256;
  localparam int PERIOD     = SEARCH_LEN + SLIP_WAIT + 1;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};

  logic       vga_clk;
  logic       sys_rst_n;
  logic [9:0] tmds_word;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [7:0] data_out;
  logic       c0;
  logic       c1;

  tmds_decoder #(
    .SEARCH_LEN (SEARCH_LEN),
    .CTRL_RUN   (CTRL_RUN),
    .SLIP_WAIT  (SLIP_WAIT),
    .LOSS_LEN   (LOSS_LEN)
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .tmds_word (tmds_word),
    .bitslip   (bitslip),
    .locked    (locked),
    .de        (de),
    .data_out  (data_out),
    .c0        (c0),
    .c1        (c1)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
  } exp_t;

  exp_t       exp_q[$];
  bit         chk_en;
  logic [1:0] mdl_c;
  int         total;
  int         bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic bit is_tok(input logic [9:0] w);
    for (int i = 0; i < 4; i++)
      if (w == TOK[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Transmit-side encoding of a byte (transition step plus optional inversion).
  function automatic logic [9:0] enc(input logic [7:0] b, input bit use_xor, input bit inv);
    logic [7:0] qm;
    qm[0] = b[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xor ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
    return {inv, use_xor, inv ? ~qm : qm};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] t;
    t = {w, w} << r;
    return t[19:10];
  endfunction

  task automatic send_data(input logic [9:0] w, input logic [7:0] b);
    exp_t e;
    @(posedge vga_clk); #1;
    tmds_word = w;
    e.de = 1'b1; e.data = b; e.c = mdl_c;
    exp_q.push_back(e);
  endtask

  task automatic send_tok(input int i);
    exp_t e;
    @(posedge vga_clk); #1;
    tmds_word = TOK[i];
    mdl_c = 2'(i);
    e.de = 1'b0; e.data = 8'h00; e.c = mdl_c;
    exp_q.push_back(e);
  endtask

  task automatic send_rand_data();
    logic [7:0] b;
    logic [9:0] w;
    do begin
      b = 8'($urandom);
      w = enc(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end while (is_tok(w));
    send_data(w, b);
  endtask

  always @(negedge vga_clk) begin
    exp_t e;
    if (chk_en && exp_q.size() > 2) begin
      e = exp_q.pop_front();
      check("sb_de", {31'd0, de}, {31'd0, e.de});
      check("sb_data", {24'd0, data_out}, {24'd0, e.data});
      check("sb_c", {30'd0, c1, c0}, {30'd0, e.c});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lock_cyc, fall_cyc, slip_cyc, slips, last_slip, rot;
    bit seen_slip, seen_de, prev_bs;
    total = 0; bad = 0;
    chk_en = 1'b0; mdl_c = 2'b00;
    sys_rst_n = 1'b0;
    tmds_word = TOK[0];

    // Reset, then a clean token stream
    repeat (4) @(posedge vga_clk);
    #1;
    check("rst_bitslip", {31'd0, bitslip}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_de", {31'd0, de}, 0);
    check("rst_data", {24'd0, data_out}, 0);
    check("rst_c", {30'd0, c1, c0}, 0);
    sys_rst_n = 1'b1;
    cyc = 0; lock_cyc = -1; seen_slip = 0;
    while (cyc < 40 && lock_cyc < 0) begin
      @(posedge vga_clk); #1;
      cyc++;
      if (bitslip) seen_slip = 1;
      if (locked) lock_cyc = cyc;
    end
    check_rng("lock_cycle", lock_cyc, 9, 11);
    check("lock_no_slip", {31'd0, seen_slip}, 0);
    check("lock_de", {31'd0, de}, 0);
    check("lock_c", {30'd0, c1, c0}, 0);

    // Decode while locked: fixed vectors, control transition, random mix
    chk_en = 1'b1;
    send_data(10'h100, 8'h00);
    send_data(10'h200, 8'hFF);
    send_data(10'h2FF, 8'hFE);
    send_tok(3);
    send_data(10'h100, 8'h00);
    for (int n = 0; n < 240; n++) begin
      if (n % 40 == 0) begin
        repeat (CTRL_RUN + 2) send_tok($urandom_range(0, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        send_tok($urandom_range(0, 3));
      end else begin
        send_rand_data();
      end
    end
    repeat (CTRL_RUN + 2) send_tok(3);
    @(posedge vga_clk); #1;
    chk_en = 1'b0;
    exp_q.delete();
    check("decode_still_locked", {31'd0, locked}, 1);

    // Lock loss on a data-only stream
    @(posedge vga_clk); #1;
    tmds_word = 10'h100;
    cyc = 0; fall_cyc = -1;
    while (cyc < LOSS_LEN + 20 && fall_cyc < 0) begin
      @(posedge vga_clk); #1;
      cyc++;
      if (!locked) fall_cyc = cyc;
    end
    check_rng("loss_cycle", fall_cyc, LOSS_LEN, LOSS_LEN + 3);
    check("loss_de", {31'd0, de}, 0);
    check("loss_data", {24'd0, data_out}, 0);
    check("loss_c_hold", {30'd0, c1, c0}, 2'b11);
    cyc = 0; slip_cyc = -1; seen_de = 0;
    while (cyc < SEARCH_LEN + 10 && slip_cyc < 0) begin
      @(posedge vga_clk); #1;
      cyc++;
      if (de || data_out != 8'h00) seen_de = 1;
      if (bitslip) slip_cyc = cyc;
    end
    check("unlocked_de_quiet", {31'd0, seen_de}, 0);
    check("first_slip_after_loss", slip_cyc, SEARCH_LEN);

    // Reset asserted on the bitslip cycle
    sys_rst_n = 1'b0;
    @(posedge vga_clk); #1;
    check("rst_slip_bitslip", {31'd0, bitslip}, 0);
    check("rst_slip_locked", {31'd0, locked}, 0);
    check("rst_slip_c", {30'd0, c1, c0}, 0);
    sys_rst_n = 1'b1;
    cyc = 0; slip_cyc = -1;
    while (cyc < SEARCH_LEN + 10 && slip_cyc < 0) begin
      @(posedge vga_clk); #1;
      cyc++;
      if (bitslip) slip_cyc = cyc;
    end
    check("slip_after_reset", slip_cyc, SEARCH_LEN);

    // Stream rotated by 3 bits; each bitslip rotates one bit back
    sys_rst_n = 1'b0;
    rot = 3;
    tmds_word = rotl(TOK[0], rot);
    repeat (2) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    cyc = 0; slips = 0; last_slip = -1; prev_bs = 0;
    while (cyc < 10 * PERIOD + 50 && !locked) begin
      @(posedge vga_clk); #1;
      cyc++;
      if (bitslip) begin
        check("slip_width", {31'd0, prev_bs}, 0);
        if (last_slip >= 0) check("slip_spacing", cyc - last_slip, PERIOD);
        last_slip = cyc;
        slips++;
        rot = (rot + 1) % 10;
      end
      prev_bs = bitslip;
      tmds_word = rotl(TOK[0], rot);
    end
    check("misalign_locked", {31'd0, locked}, 1);
    check("misalign_slips", slips, 7);
    seen_slip = 0;
    repeat (20) begin
      @(posedge vga_clk); #1;
      if (bitslip) seen_slip = 1;
    end
    check("no_slip_when_locked", {31'd0, seen_slip}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the team's TMDS transmit channel: recovers pixel data and sync/control bits from one TMDS lane.
- Input is 10-bit parallel symbols from a 1:10 deserializer running in the pixel clock domain.
- Block aligns word boundaries by pulsing bitslip to the deserializer until control tokens appear, then decodes symbols into de, 8-bit data and c0/c1.
- Three instances (B, G, R) feed a future hdmi_in top; the B lane's c0/c1 carry hsync/vsync.

Parameters:
- SEARCH_LEN, 2048: cycles observed per alignment attempt before issuing a bitslip.
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SLIP_WAIT, 4: settle cycles after a bitslip pulse before searching resumes.
- LOSS_LEN, 65536: cycles in LOCKED without a qualifying control run before lock is dropped.

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- tmds_word  in  10  deserialized symbol; bit 0 = first bit on the wire.
- bitslip  out  1  one-cycle pulse requesting a one-bit rotation from the deserializer.
- locked  out  1  high while word alignment is valid.
- de  out  1  data-enable; high for video-data symbols.
- data_out  out  8  decoded byte; 8'h00 whenever de=0.
- c0  out  1  control bit 0, held from the last control token.
- c1  out  1  control bit 1, held from the last control token.

Behaviour:
- Reset: one clock, synchronous, active-low (sys_rst_n sampled on vga_clk). While sys_rst_n=0 on a clock edge:
  - all outputs go to 0;
  - FSM goes to SEARCH;
  - all counters clear.
  - Reset mid-operation (any state, including mid-SLIP) behaves identically; no pending bitslip survives.
- Pipeline:
  - stage 1 registers tmds_word;
  - stage 2 classifies and decodes.
  - de/data_out/c0/c1 are valid 2 cycles after the symbol is presented.
- Control tokens (stage-1 word):
  - 10'b1101010100 → c=00
  - 10'b0010101011 → c=01
  - 10'b0101010100 → c=10
  - 10'b1010101011 → c=11
  - Any other word is treated as data.
- Data decode:
  - q = word[9] ? ~word[7:0] : word[7:0]
  - d[0] = q[0]
  - for i = 1..7: d[i] = word[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])
- Output when locked:
  - control token: de=0, data_out=0, c0/c1 updated.
  - data word: de=1, data_out=d, c0/c1 hold.
- Output when not locked: de=0, data_out=0, c0/c1 hold their last value (0 after reset).
- Run counter:
  - increments on each control token, saturates at CTRL_RUN;
  - clears on any non-token word.
  - Tokens need not be identical to count.
- FSM:
  - SEARCH: window counter counts to SEARCH_LEN-1.
    - Run counter reaching CTRL_RUN → LOCKED (locked=1 next cycle).
    - Window expiry without that → SLIP.
    - If both happen on the same cycle, lock wins.
  - SLIP: bitslip=1 for exactly one cycle → WAIT.
  - WAIT: SLIP_WAIT cycles; run counter held cleared → SEARCH, window counter reset.
  - LOCKED: loss counter resets each time a CTRL_RUN run completes.
    - Counter reaching LOSS_LEN-1 → SEARCH, locked=0 next cycle.
    - Decoded outputs revert to de=0 on the same cycle locked drops.
- No limit on slip attempts; wrap-around through 10 rotations is the deserializer's job.
- bitslip is never asserted while in LOCKED.
- Counter widths are $clog2 of the respective parameter.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants, shared with the transmit encoder;
  - the FSM state enum (SEARCH, SLIP, WAIT, LOCKED).
- One natural sub-module, tmds_word_align: the FSM, counters and bitslip generation. It outputs locked and is_ctrl.
- The decode datapath stays in tmds_decoder.

Test Plan:
- Reset and lock: reset 4 cycles, then 10'b1101010100 continuously. Expect:
  - no bitslip;
  - locked=1 after CTRL_RUN tokens plus pipeline (cycle 10 after reset release ±1);
  - c0=c1=0, de=0.
- Misalignment: feed a stream rotated 3 bits; the bench model rotates back one bit per bitslip. Expect:
  - bitslip pulses, each exactly one cycle, spaced SEARCH_LEN+SLIP_WAIT+1 apart;
  - lock after the 7th slip.
- Data decode when locked: 10'h100→8'h00, 10'h200→8'hFF, 10'h2FF→8'hFE, each with de=1 two cycles later.
- Control transitions: 10'b1010101011 then data 10'h100. Expect:
  - c0=1, c1=1, de=0;
  - then de=1, data_out=8'h00, c0/c1 still 1.
- Lock loss: after lock, send only 10'h100 for LOSS_LEN cycles. Expect:
  - locked falls at cycle LOSS_LEN;
  - de=0 from then on;
  - first bitslip SEARCH_LEN cycles later.
- Reset mid-SLIP: assert sys_rst_n=0 on the bitslip cycle. Expect bitslip=0 and locked=0 at the next edge, and the FSM in SEARCH.
